uart_frame_rx: RTL and testbench



---
 rtl/uart_frame_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - sync hunt, length-prefixed payload capture, checksum check and drain
module uart_frame_rx #(
    parameter int          MAX_LEN      = 16,
    parameter int          TIMEOUT_CLKS = 25000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                         i_Clock,
    input  logic                         i_Rst,
    input  logic                         i_RX_DV,
    input  logic [7:0]                   i_RX_Byte,
    output logic [7:0]                   o_Data,
    output logic                         o_Valid,
    input  logic                         i_Ready,
    output logic                         o_First,
    output logic                         o_Last,
    output logic [$clog2(MAX_LEN+1)-1:0] o_Len,
    output logic                         o_Frame_OK,
    output logic                         o_Err,
    output logic [1:0]                   o_Err_Code
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [1:0] CODE_OVERRUN = 2'd0;
    localparam logic [1:0] CODE_BAD_LEN = 2'd1;
    localparam logic [1:0] CODE_BAD_CHK = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               mem_we;
    logic [7:0]         mem_q [MAX_LEN];

    logic               valid;
    logic               rd_last;
    logic               wr_last;
    logic               expired;

    assign valid   = (state_q == ST_DRAIN);
    assign rd_last = (LEN_W'(rd_idx_q) == len_q - LEN_W'(1));
    assign wr_last = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign expired = (timer_q == TMR_W'(TIMEOUT_CLKS - 1));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rd_idx_d = rd_idx_q;
        sum_d    = sum_q;
        timer_d  = timer_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        mem_we   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                timer_d = '0;
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                // A byte on the expiry cycle wins over the timeout.
                if (i_RX_DV) begin
                    timer_d = '0;
                    if (state_q == ST_LEN) begin
                        if (i_RX_Byte == 8'd0 || i_RX_Byte > 8'(MAX_LEN)) begin
                            err_d   = 1'b1;
                            code_d  = CODE_BAD_LEN;
                            state_d = ST_HUNT;
                        end else begin
                            len_d   = LEN_W'(i_RX_Byte);
                            sum_d   = i_RX_Byte;
                            idx_d   = '0;
                            state_d = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        mem_we = 1'b1;
                        sum_d  = sum_q + i_RX_Byte;
                        if (wr_last) begin
                            state_d = ST_CHK;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (i_RX_Byte == sum_q) begin
                        ok_d     = 1'b1;
                        rd_idx_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = CODE_BAD_CHK;
                        state_d = ST_HUNT;
                    end
                end else if (expired) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    code_d  = CODE_TIMEOUT;
                    state_d = ST_HUNT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                timer_d = '0;
                if (i_RX_DV) begin
                    err_d  = 1'b1;
                    code_d = CODE_OVERRUN;
                end
                if (i_Ready) begin
                    if (rd_last) begin
                        state_d = ST_HUNT;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= ST_HUNT;
            len_q    <= '0;
            idx_q    <= '0;
            rd_idx_q <= '0;
            sum_q    <= '0;
            timer_q  <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rd_idx_q <= rd_idx_d;
            sum_q    <= sum_d;
            timer_q  <= timer_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge i_Clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= i_RX_Byte;
        end
    end

    assign o_Valid    = valid;
    assign o_Data     = valid ? mem_q[rd_idx_q] : 8'h00;
    assign o_First    = valid && (rd_idx_q == '0);
    assign o_Last     = valid && rd_last;
    assign o_Len      = len_q;
    assign o_Frame_OK = ok_q;
    assign o_Err      = err_q;
    assign o_Err_Code = code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized frame stimulus against a byte-list reference model
module tb_uart_frame_rx;

    localparam int         MAX_LEN = 16;
    localparam int         T       = 64;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       i_Clock = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_RX_DV = 1'b0;
    logic [7:0] i_RX_Byte = 8'h00;
    logic       i_Ready = 1'b0;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_First;
    logic       o_Last;
    logic [4:0] o_Len;
    logic       o_Frame_OK;
    logic       o_Err;
    logic [1:0] o_Err_Code;

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(T), .SYNC_BYTE(SYNC)) dut (
        .i_Clock(i_Clock), .i_Rst(i_Rst), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
        .o_Data(o_Data), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_First(o_First),
        .o_Last(o_Last), .o_Len(o_Len), .o_Frame_OK(o_Frame_OK), .o_Err(o_Err),
        .o_Err_Code(o_Err_Code)
    );

    always #5 i_Clock = ~i_Clock;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is the list of bytes seen after sync; good frames queue their payload.
    logic [7:0] frm[$];
    logic [7:0] pend[$];
    bit         in_frame;
    int         gap;
    logic       m_err, m_ok;
    logic [1:0] m_code;
    int         m_len;

    always @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            frm.delete(); pend.delete();
            in_frame = 0; gap = 0; m_err = 0; m_ok = 0; m_code = 0; m_len = 0;
        end else begin
            m_err = 0; m_ok = 0;
            if (pend.size() > 0) begin
                if (i_RX_DV) begin m_err = 1; m_code = 0; end
                if (i_Ready) void'(pend.pop_front());
            end else if (!in_frame) begin
                if (i_RX_DV && i_RX_Byte == SYNC) begin in_frame = 1; frm.delete(); gap = 0; end
            end else if (i_RX_DV) begin
                gap = 0;
                frm.push_back(i_RX_Byte);
                if (frm.size() == 1) begin
                    if (i_RX_Byte == 0 || i_RX_Byte > MAX_LEN) begin
                        m_err = 1; m_code = 1; in_frame = 0;
                    end else begin
                        m_len = int'(i_RX_Byte);
                    end
                end else if (frm.size() == int'(frm[0]) + 2) begin
                    int s;
                    s = 0;
                    for (int i = 0; i < frm.size() - 1; i++) s += int'(frm[i]);
                    in_frame = 0;
                    if (s % 256 == int'(i_RX_Byte)) begin
                        m_ok = 1;
                        for (int i = 1; i <= int'(frm[0]); i++) pend.push_back(frm[i]);
                    end else begin
                        m_err = 1; m_code = 2;
                    end
                end
            end else begin
                gap++;
                if (gap == T) begin m_err = 1; m_code = 3; in_frame = 0; end
            end
        end
    end

    int         n_ok, n_err, mdl_ok;
    logic [7:0] obs[$];

    always @(negedge i_Clock) begin
        chk("err", o_Err, m_err);
        chk("err_code", o_Err_Code, m_code);
        chk("frame_ok", o_Frame_OK, m_ok);
        chk("valid", o_Valid, pend.size() > 0);
        if (pend.size() > 0) begin
            chk("data", o_Data, pend[0]);
            chk("first", o_First, pend.size() == m_len);
            chk("last", o_Last, pend.size() == 1);
            chk("len", o_Len, m_len);
        end
        if (o_Err) n_err++;
        if (o_Frame_OK) n_ok++;
        if (m_ok) mdl_ok++;
        if (o_Valid && i_Ready) obs.push_back(o_Data);
    end

    int   rdy_mode = 0;
    int   pi = 0;
    logic pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] txq[$];

    task automatic tick();
        @(posedge i_Clock);
        #1;
        i_RX_DV = 1'b0;
        case (rdy_mode)
            0: i_Ready = 1'b1;
            1: i_Ready = 1'($urandom_range(0, 1));
            2: begin i_Ready = (pi < 6) ? pat[pi] : 1'b1; pi++; end
            default: i_Ready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        i_RX_DV = 1'b1;
        i_RX_Byte = b;
    endtask

    task automatic send_q(input int maxgap);
        foreach (txq[i]) begin
            send(txq[i]);
            idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic build(input int len, input bit bad);
        int s;
        logic [7:0] b;
        txq.delete();
        txq.push_back(SYNC);
        txq.push_back(8'(len));
        s = len;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            txq.push_back(b);
            s += int'(b);
        end
        txq.push_back(8'(s) ^ (bad ? 8'h01 : 8'h00));
    endtask

    task automatic drain_wait();
        int k;
        k = 0;
        while ((pend.size() > 0 || in_frame) && k < 2000) begin tick(); k++; end
        chk("drain_bound", k < 2000, 1);
        idle(3);
    endtask

    task automatic clear();
        obs.delete(); n_ok = 0; n_err = 0; mdl_ok = 0;
    endtask

    initial begin
        idle(3);
        chk("rst_valid", o_Valid, 0);
        chk("rst_err", o_Err, 0);
        chk("rst_ok", o_Frame_OK, 0);
        chk("rst_len", o_Len, 0);
        chk("rst_code", o_Err_Code, 0);
        chk("rst_data", {o_Data, o_First, o_Last}, 0);
        i_Rst = 1'b0;
        idle(2);

        clear();
        txq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_q(0);
        drain_wait();
        chk("t1_ok_cnt", n_ok, 1);
        chk("t1_model_ok", mdl_ok, 1);
        chk("t1_err_cnt", n_err, 0);
        chk("t1_n", obs.size(), 3);
        chk("t1_b0", obs[0], 8'h11);
        chk("t1_b1", obs[1], 8'h22);
        chk("t1_b2", obs[2], 8'h33);

        clear();
        rdy_mode = 1;
        send_q(2);
        rdy_mode = 2; pi = 0;
        drain_wait();
        rdy_mode = 0;
        chk("t2_n", obs.size(), 3);
        chk("t2_bytes", {obs[0], obs[1], obs[2]}, 24'h112233);

        clear();
        txq = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_q(1);
        drain_wait();
        chk("t3_err_cnt", n_err, 1);
        chk("t3_code", o_Err_Code, 2);
        chk("t3_n", obs.size(), 0);
        clear();
        build(4, 0);
        send_q(1);
        drain_wait();
        chk("t3_good_n", obs.size(), 4);

        clear();
        txq = {8'hA5, 8'h00, 8'hA5, 8'h11};
        send_q(1);
        drain_wait();
        chk("t4_err_cnt", n_err, 2);
        chk("t4_code", o_Err_Code, 1);
        clear();
        build(16, 0);
        send_q(1);
        drain_wait();
        chk("t4_max_n", obs.size(), 16);
        chk("t4_max_last", obs[15], txq[17]);

        clear();
        send(8'hA5); send(8'h02); send(8'hAA);
        idle(T);
        send(8'hBB); send(8'h67);
        drain_wait();
        chk("t5_late_err", n_err, 1);
        chk("t5_late_code", o_Err_Code, 3);
        chk("t5_late_ok", n_ok, 0);
        clear();
        send(8'hA5); send(8'h02); send(8'hAA);
        idle(T - 1);
        send(8'hBB); send(8'h67);
        drain_wait();
        chk("t5_edge_err", n_err, 0);
        chk("t5_edge_ok", n_ok, 1);
        chk("t5_edge_bytes", {obs.size() == 2, obs[0], obs[1]}, {1'b1, 16'hAABB});

        clear();
        rdy_mode = 3;
        txq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_q(0);
        idle(2);
        send(8'hA5);
        idle(2);
        rdy_mode = 0;
        drain_wait();
        chk("t6_err_cnt", n_err, 1);
        chk("t6_code", o_Err_Code, 0);
        chk("t6_bytes", {obs.size() == 3, obs[0], obs[1], obs[2]}, {1'b1, 24'h112233});

        clear();
        txq = {8'hA5, 8'h05, 8'h01, 8'h02};
        send_q(0);
        idle(1);
        i_Rst = 1'b1;
        idle(2);
        chk("t7_valid", o_Valid, 0);
        chk("t7_len", o_Len, 0);
        chk("t7_flags", {o_Err, o_Frame_OK, o_Err_Code}, 0);
        i_Rst = 1'b0;
        idle(1);
        build(5, 0);
        send_q(1);
        drain_wait();
        chk("t7_new_n", obs.size(), 5);

        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom));
            build($urandom_range(1, MAX_LEN), $urandom_range(0, 3) == 0);
            send_q(3);
            if ($urandom_range(0, 4) != 0) drain_wait();
        end
        drain_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
